// File: rtl/fp_classify_pipe_if.sv
// Handshake bundle for fp_classify_pipe: operand stream in, fclass masks and NaN flags out.
// slave = classifier side, master = producer/consumer side.
interface fp_classify_pipe_if #(
  parameter int LANES = 4,
  parameter int FP_W  = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*FP_W-1:0]  in_data;
  logic [LANES-1:0]       in_lane_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*10-1:0]    out_class;
  logic                   out_any_nan;
  logic                   out_any_snan;

  modport slave (
    input  in_valid, in_data, in_lane_en, out_ready,
    output in_ready, out_valid, out_class, out_any_nan, out_any_snan
  );

  modport master (
    output in_valid, in_data, in_lane_en, out_ready,
    input  in_ready, out_valid, out_class, out_any_nan, out_any_snan
  );
endinterface

// File: rtl/fp_classify_pipe.sv
// Multi-lane IEEE-754 fclass with a 2-entry output skid FIFO.
// Define FP_CLASSIFY_PIPE_CNT_EN to add saturating NaN/sNaN lane counters.

module fp_class_lane #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] fp,
  input  logic                            en,
  output logic [9:0]                      cls
);
  localparam int FP_W = SIGN_W + EXPO_W + MANT_W;

  logic              sign;
  logic [EXPO_W-1:0] expo;
  logic [MANT_W-1:0] mant;
  logic expo_max, expo_zero, mant_zero;
  logic is_nan, is_inf, is_zero, is_sub, is_norm;

  // Sign is the MSB of the sign field, which is also the MSB of the word.
  assign sign = fp[FP_W-1];
  assign expo = fp[MANT_W +: EXPO_W];
  assign mant = fp[MANT_W-1:0];

  assign expo_max  = &expo;
  assign expo_zero = ~|expo;
  assign mant_zero = ~|mant;

  assign is_nan  = expo_max  & ~mant_zero;
  assign is_inf  = expo_max  &  mant_zero;
  assign is_zero = expo_zero &  mant_zero;
  assign is_sub  = expo_zero & ~mant_zero;
  assign is_norm = ~expo_max & ~expo_zero;

  assign cls = en ? {is_nan & mant[MANT_W-1], is_nan & ~mant[MANT_W-1],
                     is_inf & ~sign, is_norm & ~sign, is_sub & ~sign, is_zero & ~sign,
                     is_zero & sign, is_sub & sign, is_norm & sign, is_inf & sign}
                  : 10'b0;
endmodule

module fp_classify_pipe #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_classify_pipe_if.slave     bus
`ifdef FP_CLASSIFY_PIPE_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      cnt_nan,
  output logic [CNT_W-1:0]      cnt_snan
`endif
);
  localparam int FP_W = SIGN_W + EXPO_W + MANT_W;

  typedef struct packed {
    logic [LANES-1:0][9:0] cls;
    logic                  any_nan;
    logic                  any_snan;
  } entry_t;

  logic [LANES-1:0][FP_W-1:0] lane_data;
  logic [LANES-1:0][9:0]      new_cls;
  entry_t                     new_entry;

  assign lane_data = bus.in_data;

  fp_class_lane #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_lane [LANES-1:0] (
    .fp  (lane_data),
    .en  (bus.in_lane_en),
    .cls (new_cls)
  );

  // Disabled lanes already produce a zero mask, so flags need no extra gating.
  always_comb begin
    new_entry          = '0;
    new_entry.cls      = new_cls;
    for (int i = 0; i < LANES; i++) begin
      new_entry.any_nan  = new_entry.any_nan  | new_cls[i][8] | new_cls[i][9];
      new_entry.any_snan = new_entry.any_snan | new_cls[i][8];
    end
  end

  entry_t     mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] occ, occ_nxt;
  logic       in_ready_q;
  logic       in_fire, out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (occ != 2'd0) & bus.out_ready;

  always_comb begin
    occ_nxt = occ;
    if (in_fire && !out_fire)      occ_nxt = occ + 2'd1;
    else if (!in_fire && out_fire) occ_nxt = occ - 2'd1;
  end

  // in_ready comes from next occupancy only, so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) mem[k] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (in_fire) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
      occ        <= occ_nxt;
      in_ready_q <= (occ_nxt != 2'd2);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (occ != 2'd0);
  assign bus.out_class    = mem[rd_ptr].cls;
  assign bus.out_any_nan  = mem[rd_ptr].any_nan;
  assign bus.out_any_snan = mem[rd_ptr].any_snan;

`ifdef FP_CLASSIFY_PIPE_CNT_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  nan_pop, snan_pop;
  logic [SUM_W-1:0] nan_sum, snan_sum;
  logic [CNT_W-1:0] nan_sat, snan_sat;

  always_comb begin
    nan_pop  = '0;
    snan_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      nan_pop  = nan_pop  + PC_W'(new_cls[i][8] | new_cls[i][9]);
      snan_pop = snan_pop + PC_W'(new_cls[i][8]);
    end
  end

  assign nan_sum  = SUM_W'(cnt_nan)  + SUM_W'(nan_pop);
  assign snan_sum = SUM_W'(cnt_snan) + SUM_W'(snan_pop);
  assign nan_sat  = (nan_sum  > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : nan_sum[CNT_W-1:0];
  assign snan_sat = (snan_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : snan_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_nan  <= '0;
      cnt_snan <= '0;
    end else if (in_fire) begin
      cnt_nan  <= nan_sat;
      cnt_snan <= snan_sat;
    end
  end
`endif
endmodule

// File: tb/tb_fp_classify_pipe.sv
// Self-checking bench for fp_classify_pipe (FP32, 4 lanes); counter test runs when FP_CLASSIFY_PIPE_CNT_EN is defined.
module tb_fp_classify_pipe;
  localparam int LANES = 4;
  localparam int FP_W  = 32;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_classify_pipe_if #(.LANES(LANES), .FP_W(FP_W)) bus ();

`ifdef FP_CLASSIFY_PIPE_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_nan, cnt_snan;
`endif

  fp_classify_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FP_CLASSIFY_PIPE_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .cnt_nan  (cnt_nan),
    .cnt_snan (cnt_snan)
`endif
  );

  typedef struct packed {
    logic [LANES*10-1:0] cls;
    logic                nan;
    logic                snan;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Class index by magnitude k (zero,sub,normal,inf): negatives sit at 3-k, positives at 4+k.
  function automatic logic [9:0] ref_class(input logic [31:0] x, input logic en);
    int k;
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (!en) return 10'h000;
    if (e == 8'hFF && m != 0) return m[22] ? 10'h200 : 10'h100;
    if (e == 8'h00)      k = (m == 0) ? 0 : 1;
    else if (e == 8'hFF) k = 3;
    else                 k = 2;
    return 10'h001 << (x[31] ? 3 - k : 4 + k);
  endfunction

  function automatic exp_t ref_txn(input logic [LANES*FP_W-1:0] d, input logic [LANES-1:0] en);
    exp_t r;
    logic [9:0] c;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      c = ref_class(d[i*FP_W +: FP_W], en[i]);
      r.cls[i*10 +: 10] = c;
      if (c[8] || c[9]) r.nan = 1'b1;
      if (c[8])         r.snan = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [LANES*FP_W-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom % 4)
      0: e = 8'h00;
      1: e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    case ($urandom % 4)
      0: m = 23'h0;
      1: m = {1'b1, 22'($urandom)};
      2: m = {1'b0, 22'($urandom)};
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_lane_en = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_class !== '0) begin errors++; $display("FAIL reset_out_class: got %h expected 0", bus.out_class); end
    checks++; if ({bus.out_any_nan, bus.out_any_snan} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.out_any_nan, bus.out_any_snan}); end
`ifdef FP_CLASSIFY_PIPE_CNT_EN
    checks++; if ({cnt_nan, cnt_snan} !== '0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {cnt_nan, cnt_snan}); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_t1_classes();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_lane_en = 4'hF;
    bus.in_data    = pack4(32'h7F800000, 32'hFF800001, 32'h7FC00000, 32'h80000000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t1_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_class !== {10'h008, 10'h200, 10'h100, 10'h080}) begin errors++; $display("FAIL t1_out_class: got %h expected %h", bus.out_class, {10'h008, 10'h200, 10'h100, 10'h080}); end
    checks++; if ({bus.out_any_nan, bus.out_any_snan} !== 2'b11) begin errors++; $display("FAIL t1_flags: got %b expected 11", {bus.out_any_nan, bus.out_any_snan}); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_t2_lane_en();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_lane_en = 4'b1011;
    bus.in_data    = pack4(32'h00000001, 32'h3F800000, 32'h807FFFFF, 32'hFF800000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_class !== {10'h001, 10'h000, 10'h040, 10'h020}) begin errors++; $display("FAIL t2_out_class: got %h expected %h", bus.out_class, {10'h001, 10'h000, 10'h040, 10'h020}); end
    checks++; if ({bus.out_any_nan, bus.out_any_snan} !== 2'b00) begin errors++; $display("FAIL t2_flags: got %b expected 00", {bus.out_any_nan, bus.out_any_snan}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [LANES*FP_W-1:0] vec [3];
    exp_t ea;
    exp_t got [$];
    int accepted;
    vec[0] = pack4(32'h7F800001, 32'h00000000, 32'h3F800000, 32'hFFC00000);
    vec[1] = pack4(32'h80000001, 32'hFF800000, 32'h7F800000, 32'h80000000);
    vec[2] = pack4(32'h40490FDB, 32'h7FA00000, 32'h00400000, 32'hC0000000);
    ea = ref_txn(vec[0], 4'hF);
    accepted = 0;
    bus.in_lane_en = 4'hF;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        checks++; if (bus.in_ready !== 1'b0 || accepted != 2) begin errors++; $display("FAIL t3_full_stall: in_ready %b accepted %0d expected 0 and 2", bus.in_ready, accepted); end
      end
      if (cyc >= 3 && cyc <= 5) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== ea.cls) begin errors++; $display("FAIL t3_hold_stable: valid %b class %h expected 1 and %h", bus.out_valid, bus.out_class, ea.cls); end
      end
      bus.in_valid  = (accepted < 3);
      bus.in_data   = vec[(accepted < 3) ? accepted : 2];
      bus.out_ready = (cyc >= 6);
      if (bus.out_valid && bus.out_ready) got.push_back('{cls: bus.out_class, nan: bus.out_any_nan, snan: bus.out_any_snan});
      if (bus.in_valid && bus.in_ready) accepted++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL t3_drain_count: got %0d expected 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      ea = ref_txn(vec[k], 4'hF);
      checks++; if (got[k] !== ea) begin errors++; $display("FAIL t3_order_%0d: got %h expected %h", k, got[k], ea); end
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_lane_en = 4'hF;
    bus.in_data    = pack4(32'h7F800001, 32'h7F800001, 32'h7F800001, 32'h7F800001);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL t4_prefill: in_ready %b out_valid %b expected 0 1", bus.in_ready, bus.out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL t4_in_reset: out_valid %b in_ready %b expected 0 0", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_class !== '0 || bus.out_any_snan !== 1'b0) begin errors++; $display("FAIL t4_cleared: class %h snan %b expected 0", bus.out_class, bus.out_any_snan); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_after_reset: in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_no_stale: out_valid %b expected 0", bus.out_valid); end
  endtask

`ifdef FP_CLASSIFY_PIPE_CNT_EN
  task automatic test_counters();
    int   m_nan, m_snan;
    exp_t e;
    logic [LANES*FP_W-1:0] d;
    d = pack4(32'h7F800000, 32'hFF800001, 32'h7FC00000, 32'h80000000);
    e = ref_txn(d, 4'hF);
    m_nan = 0;
    m_snan = 0;
    bus.out_ready  = 1'b1;
    bus.in_lane_en = 4'hF;
    bus.in_data    = d;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (cnt_nan !== CNT_W'(m_nan) || cnt_snan !== CNT_W'(m_snan)) begin errors++; $display("FAIL t5_count_%0d: got %0d/%0d expected %0d/%0d", k, cnt_nan, cnt_snan, m_nan, m_snan); end
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        for (int i = 0; i < LANES; i++) begin
          if (e.cls[i*10+8] || e.cls[i*10+9]) m_nan++;
          if (e.cls[i*10+8]) m_snan++;
        end
        if (m_nan > 3) m_nan = 3;
        if (m_snan > 3) m_snan = 3;
      end
    end
    @(negedge clk);
    checks++; if (cnt_nan !== 2'd3 || cnt_snan !== 2'd3) begin errors++; $display("FAIL t5_saturate: got %0d/%0d expected 3/3", cnt_nan, cnt_snan); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (cnt_nan !== 2'd0 || cnt_snan !== 2'd0) begin errors++; $display("FAIL t5_clear_priority: got %0d/%0d expected 0/0", cnt_nan, cnt_snan); end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    localparam int N = 10000;
    exp_t q [$];
    exp_t e;
    int sent, cyc, lane_ones;
    sent = 0;
    cyc = 0;
    bus.in_valid = 1'b0;
    while ((sent < N || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid: got %b expected %b at cycle %0d", bus.out_valid, q.size() != 0, cyc); end
      checks++; if (bus.in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready: got %b expected %b at cycle %0d", bus.in_ready, q.size() < 2, cyc); end
      if (q.size() != 0) begin
        e = q[0];
        checks++; if ({bus.out_class, bus.out_any_nan, bus.out_any_snan} !== e) begin errors++; $display("FAIL rnd_data: got %h/%b%b expected %h/%b%b at cycle %0d", bus.out_class, bus.out_any_nan, bus.out_any_snan, e.cls, e.nan, e.snan, cyc); end
        lane_ones = 0;
        for (int i = 0; i < LANES; i++) if ($countones(bus.out_class[i*10 +: 10]) > 1) lane_ones++;
        checks++; if (lane_ones != 0) begin errors++; $display("FAIL rnd_onehot: %0d lanes not one-hot, class %h", lane_ones, bus.out_class); end
      end
      bus.in_valid   = (sent < N) && ($urandom % 4 != 0);
      bus.in_data    = pack4(rand_fp(), rand_fp(), rand_fp(), rand_fp());
      bus.in_lane_en = 4'($urandom);
      bus.out_ready  = ($urandom % 3 != 0);
      if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_txn(bus.in_data, bus.in_lane_en));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (sent != N || q.size() != 0) begin errors++; $display("FAIL rnd_timeout: sent %0d pending %0d expected %0d and 0", sent, q.size(), N); end
  endtask

  initial begin
    test_reset();
    test_t1_classes();
    test_t2_lane_en();
    test_back_to_back();
    test_mid_reset();
`ifdef FP_CLASSIFY_PIPE_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
